uart_frame_rx: RTL and testbench

Receive-side frame assembler for the UART link. It collects bytes from the UART receiver into a fixed-length frame, 40 bytes or 320 bits by default. It then presents the whole frame to the consumer with a valid/ack handshake. Byte order is LSB-first: the first byte received lands in data[7:0]. The block aborts partial frames on inter-byte timeout and flags bytes lost while a frame is unacknowledged.

---
 rtl/uart_frame_rx.sv | 176 +++++++++++++++++
 tb/tb_uart_frame_rx.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_rx.sv
// uart_frame_rx: collects bytes from the UART receiver into a fixed-length,
// LSB-first frame and hands it to the consumer with a valid/ack handshake.
// Partial frames are abandoned after an inter-byte idle timeout. Bytes that
// arrive while a finished frame is still unacknowledged are dropped and
// flagged in the sticky overrun bit.
module uart_frame_rx #(
  parameter int unsigned FRAME_BYTES    = 40,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       uart_read_done,
  input  logic [7:0]                 read_data,
  input  logic                       frame_ack,
  output logic [8*FRAME_BYTES-1:0]   data,
  output logic                       frame_valid,
  output logic                       frame_err,
  output logic                       overrun,
  output logic [7:0]                 byte_cnt,
  output logic [3:0]                 sta
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    HOLD = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [7:0]  LAST_IDX = 8'(FRAME_BYTES - 1);
  localparam logic        SINGLE   = (FRAME_BYTES == 1);
  localparam logic        TO_EN    = (TIMEOUT_CYCLES != 0);
  localparam logic [32:0] TO_LIMIT = 33'(TIMEOUT_CYCLES);

  state_t                   r_state;
  logic                     r_rd_q;
  logic [8*FRAME_BYTES-1:0] r_data;
  logic                     r_frame_valid;
  logic                     r_frame_err;
  logic                     r_overrun;
  logic [7:0]               r_byte_cnt;
  logic [31:0]              r_to_cnt;

  logic                     w_strobe;
  logic                     w_cap;
  logic [7:0]               w_cap_idx;
  logic [32:0]              w_to_next;
  logic                     w_to_hit;

  // Rising-edge detect on the receiver's byte-ready level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rd_q <= 1'b0;
    else      r_rd_q <= uart_read_done;
  end

  // Strobe, capture enable/slot and timeout-threshold decode
  always_comb begin
    w_strobe  = uart_read_done & ~r_rd_q;
    w_cap     = 1'b0;
    w_cap_idx = 8'd0;
    case (r_state)
      IDLE, ERR: w_cap = w_strobe;
      RECV: begin
        w_cap     = w_strobe;
        w_cap_idx = r_byte_cnt;
      end
      HOLD:      w_cap = w_strobe & frame_ack;
      default:   w_cap = 1'b0;
    endcase
    // Timeout fires on the edge where the counter would reach the limit
    w_to_next = {1'b0, r_to_cnt} + 33'd1;
    w_to_hit  = TO_EN && (w_to_next >= TO_LIMIT);
  end

  // Byte lane write into the frame buffer; aborted partial data is kept
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data <= '0;
    end else if (w_cap) begin
      for (int unsigned i = 0; i < FRAME_BYTES; i++) begin
        if (i == 32'(w_cap_idx)) r_data[8*i +: 8] <= read_data;
      end
    end
  end

  // Frame assembly FSM with registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun     <= 1'b0;
      r_byte_cnt    <= '0;
      r_to_cnt      <= '0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_byte_cnt <= '0;
          r_to_cnt   <= '0;
          if (w_strobe) begin
            if (SINGLE) begin
              r_state       <= HOLD;
              r_frame_valid <= 1'b1;
            end else begin
              r_state    <= RECV;
              r_byte_cnt <= 8'd1;
            end
          end
        end
        RECV: begin
          if (w_strobe) begin
            r_to_cnt <= '0;
            if (r_byte_cnt == LAST_IDX) begin
              r_state       <= HOLD;
              r_byte_cnt    <= '0;
              r_frame_valid <= 1'b1;
            end else begin
              r_byte_cnt <= r_byte_cnt + 8'd1;
            end
          end else if (w_to_hit) begin
            r_state     <= ERR;
            r_frame_err <= 1'b1;
            r_byte_cnt  <= '0;
            r_to_cnt    <= '0;
          end else if (r_to_cnt != '1) begin
            r_to_cnt <= r_to_cnt + 32'd1;
          end
        end
        HOLD: begin
          r_to_cnt <= '0;
          if (frame_ack) begin
            r_frame_valid <= 1'b0;
            r_overrun     <= 1'b0;
            if (w_strobe) begin
              if (SINGLE) begin
                r_frame_valid <= 1'b1;
              end else begin
                r_state    <= RECV;
                r_byte_cnt <= 8'd1;
              end
            end else begin
              r_state <= IDLE;
            end
          end else if (w_strobe) begin
            r_overrun <= 1'b1;
          end
        end
        ERR: begin
          r_byte_cnt <= '0;
          r_to_cnt   <= '0;
          if (w_strobe) begin
            if (SINGLE) begin
              r_state       <= HOLD;
              r_frame_valid <= 1'b1;
            end else begin
              r_state    <= RECV;
              r_byte_cnt <= 8'd1;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign data        = r_data;
  assign frame_valid = r_frame_valid;
  assign frame_err   = r_frame_err;
  assign overrun     = r_overrun;
  assign byte_cnt    = r_byte_cnt;
  assign sta         = {2'b00, r_state};

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed scenarios for the UART frame assembler,
// 40-byte frames with a 20-cycle inter-byte timeout.
module tb_uart_frame_rx;

  localparam int unsigned FB = 40;
  localparam int unsigned TO = 20;

  logic            clk = 1'b0;
  logic            rst;
  logic            uart_read_done;
  logic [7:0]      read_data;
  logic            frame_ack;
  logic [8*FB-1:0] data;
  logic            frame_valid;
  logic            frame_err;
  logic            overrun;
  logic [7:0]      byte_cnt;
  logic [3:0]      sta;

  int              checks = 0;
  int              errors = 0;
  logic [8*FB-1:0] exp_data;

  uart_frame_rx #(.FRAME_BYTES(FB), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .uart_read_done(uart_read_done),
    .read_data(read_data), .frame_ack(frame_ack), .data(data),
    .frame_valid(frame_valid), .frame_err(frame_err), .overrun(overrun),
    .byte_cnt(byte_cnt), .sta(sta)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task tick;
    @(posedge clk);
    #1;
  endtask

  task send_byte(input logic [7:0] b);
    read_data      = b;
    uart_read_done = 1'b1;
    repeat (3) tick;
    uart_read_done = 1'b0;
    repeat (5) tick;
  endtask

  task send_frame(input logic [7:0] seed);
    for (int i = 0; i < FB; i++) begin
      exp_data[8*i +: 8] = seed + 8'(i);
      send_byte(seed + 8'(i));
    end
  endtask

  task pulse_ack;
    frame_ack = 1'b1;
    tick;
    frame_ack = 1'b0;
  endtask

  task test_reset;
    rst = 1'b0;
    repeat (3) tick;
    checks++; if (data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", data); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", frame_valid); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", overrun); end
    checks++; if (byte_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", byte_cnt); end
    checks++; if (sta !== 4'd0) begin errors++; $display("FAIL reset_sta got %0d exp 0", sta); end
    rst = 1'b1;
    tick;
  endtask

  task test_full_frame;
    for (int i = 0; i < FB - 1; i++) begin
      exp_data[8*i +: 8] = 8'(i);
      send_byte(8'(i));
    end
    exp_data[8*(FB-1) +: 8] = 8'h27;
    checks++; if (byte_cnt !== 8'd39) begin errors++; $display("FAIL full_cnt39 got %0d exp 39", byte_cnt); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL full_early_valid got %b exp 0", frame_valid); end
    read_data      = 8'h27;
    uart_read_done = 1'b1;
    tick;
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL full_latency_valid got %b exp 1", frame_valid); end
    checks++; if (sta !== 4'd2) begin errors++; $display("FAIL full_sta_hold got %0d exp 2", sta); end
    checks++; if (byte_cnt !== 8'd0) begin errors++; $display("FAIL full_cnt_hold got %0d exp 0", byte_cnt); end
    repeat (2) tick;
    uart_read_done = 1'b0;
    repeat (5) tick;
    checks++; if (data[7:0] !== 8'h00) begin errors++; $display("FAIL full_byte0 got %h exp 00", data[7:0]); end
    checks++; if (data[319:312] !== 8'h27) begin errors++; $display("FAIL full_byte39 got %h exp 27", data[319:312]); end
    checks++; if (data !== exp_data) begin errors++; $display("FAIL full_data got %h exp %h", data, exp_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL full_err got %b exp 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL full_overrun got %b exp 0", overrun); end
    pulse_ack;
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL full_ack_valid got %b exp 0", frame_valid); end
    checks++; if (sta !== 4'd0) begin errors++; $display("FAIL full_ack_sta got %0d exp 0", sta); end
  endtask

  task test_held_high;
    int pulses;
    pulses         = 0;
    read_data      = 8'hA5;
    uart_read_done = 1'b1;
    tick;
    for (int k = 1; k < 50; k++) begin
      tick;
      if (frame_err === 1'b1) pulses++;
      if (k == 14) begin
        checks++; if (byte_cnt !== 8'd1) begin errors++; $display("FAIL held_cnt got %0d exp 1", byte_cnt); end
        checks++; if (data[7:0] !== 8'hA5) begin errors++; $display("FAIL held_byte0 got %h exp a5", data[7:0]); end
      end
    end
    // held level causes no extra strobes, so the lone byte times out once
    checks++; if (pulses !== 1) begin errors++; $display("FAIL held_err_pulses got %0d exp 1", pulses); end
    checks++; if (byte_cnt !== 8'd0) begin errors++; $display("FAIL held_cnt_after got %0d exp 0", byte_cnt); end
    checks++; if (sta !== 4'd0) begin errors++; $display("FAIL held_sta_after got %0d exp 0", sta); end
    uart_read_done = 1'b0;
    tick;
  endtask

  task test_timeout;
    int pulses;
    int first;
    pulses = 0;
    first  = 0;
    for (int i = 0; i < 4; i++) send_byte(8'(i));
    read_data      = 8'h04;
    uart_read_done = 1'b1;
    tick;
    checks++; if (byte_cnt !== 8'd5) begin errors++; $display("FAIL to_cnt5 got %0d exp 5", byte_cnt); end
    for (int k = 1; k <= 40; k++) begin
      if (k == 3) uart_read_done = 1'b0;
      tick;
      if (frame_err === 1'b1) begin
        pulses++;
        if (first == 0) first = k;
      end
    end
    checks++; if (first !== 20) begin errors++; $display("FAIL to_delay got %0d exp 20", first); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL to_pulses got %0d exp 1", pulses); end
    checks++; if (byte_cnt !== 8'd0) begin errors++; $display("FAIL to_cnt_after got %0d exp 0", byte_cnt); end
    checks++; if (sta !== 4'd0) begin errors++; $display("FAIL to_sta_after got %0d exp 0", sta); end
    send_frame(8'h30);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL to_next_valid got %b exp 1", frame_valid); end
    checks++; if (data !== exp_data) begin errors++; $display("FAIL to_next_data got %h exp %h", data, exp_data); end
    pulse_ack;
  endtask

  task test_overrun;
    send_frame(8'h40);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_initial got %b exp 0", overrun); end
    send_byte(8'hEE);
    send_byte(8'hEF);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", overrun); end
    checks++; if (data !== exp_data) begin errors++; $display("FAIL ovr_data got %h exp %h", data, exp_data); end
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid got %b exp 1", frame_valid); end
    checks++; if (sta !== 4'd2) begin errors++; $display("FAIL ovr_sta got %0d exp 2", sta); end
    pulse_ack;
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL ovr_ack_valid got %b exp 0", frame_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_ack_clear got %b exp 0", overrun); end
  endtask

  task test_ack_with_strobe;
    send_frame(8'h50);
    frame_ack      = 1'b1;
    read_data      = 8'h5A;
    uart_read_done = 1'b1;
    tick;
    frame_ack = 1'b0;
    checks++; if (data[7:0] !== 8'h5A) begin errors++; $display("FAIL ackstb_byte0 got %h exp 5a", data[7:0]); end
    checks++; if (byte_cnt !== 8'd1) begin errors++; $display("FAIL ackstb_cnt got %0d exp 1", byte_cnt); end
    checks++; if (sta !== 4'd1) begin errors++; $display("FAIL ackstb_sta got %0d exp 1", sta); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL ackstb_valid got %b exp 0", frame_valid); end
    repeat (2) tick;
    uart_read_done = 1'b0;
    repeat (5) tick;
    exp_data[7:0] = 8'h5A;
    for (int i = 1; i < FB; i++) begin
      exp_data[8*i +: 8] = 8'h80 + 8'(i);
      send_byte(8'h80 + 8'(i));
    end
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL ackstb_next_valid got %b exp 1", frame_valid); end
    checks++; if (data !== exp_data) begin errors++; $display("FAIL ackstb_next_data got %h exp %h", data, exp_data); end
    pulse_ack;
  endtask

  task test_async_reset;
    for (int i = 0; i < 17; i++) send_byte(8'h10 + 8'(i));
    checks++; if (byte_cnt !== 8'd17) begin errors++; $display("FAIL arst_cnt17 got %0d exp 17", byte_cnt); end
    #3;
    rst = 1'b0;
    #1;
    checks++; if (data !== '0) begin errors++; $display("FAIL arst_data got %h exp 0", data); end
    checks++; if (byte_cnt !== 8'd0) begin errors++; $display("FAIL arst_cnt got %0d exp 0", byte_cnt); end
    checks++; if (sta !== 4'd0) begin errors++; $display("FAIL arst_sta got %0d exp 0", sta); end
    checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", frame_valid); end
    rst = 1'b1;
    send_frame(8'h60);
    checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL arst_next_valid got %b exp 1", frame_valid); end
    checks++; if (data !== exp_data) begin errors++; $display("FAIL arst_next_data got %h exp %h", data, exp_data); end
    pulse_ack;
  endtask

  initial begin
    rst            = 1'b0;
    uart_read_done = 1'b0;
    read_data      = 8'h00;
    frame_ack      = 1'b0;
    exp_data       = '0;
    test_reset;
    test_full_frame;
    test_held_high;
    test_timeout;
    test_overrun;
    test_ack_with_strobe;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
